// File: rtl/axi4_sys_bus_bridge_if.sv
// AXI4 slave port and single-beat system bus
// shared by the burst bridge and its master.
interface axi4_sys_bus_bridge_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int IW = 12
);
  logic [IW-1:0]   axi_awid_i;
  logic [AW-1:0]   axi_awaddr_i;
  logic [7:0]      axi_awlen_i;
  logic [2:0]      axi_awsize_i;
  logic [1:0]      axi_awburst_i;
  logic            axi_awvalid_i;
  logic            axi_awready_o;
  logic [DW-1:0]   axi_wdata_i;
  logic [DW/8-1:0] axi_wstrb_i;
  logic            axi_wlast_i;
  logic            axi_wvalid_i;
  logic            axi_wready_o;
  logic [IW-1:0]   axi_bid_o;
  logic [1:0]      axi_bresp_o;
  logic            axi_bvalid_o;
  logic            axi_bready_i;
  logic [IW-1:0]   axi_arid_i;
  logic [AW-1:0]   axi_araddr_i;
  logic [7:0]      axi_arlen_i;
  logic [2:0]      axi_arsize_i;
  logic [1:0]      axi_arburst_i;
  logic            axi_arvalid_i;
  logic            axi_arready_o;
  logic [IW-1:0]   axi_rid_o;
  logic [DW-1:0]   axi_rdata_o;
  logic [1:0]      axi_rresp_o;
  logic            axi_rlast_o;
  logic            axi_rvalid_o;
  logic            axi_rready_i;
  logic [AW-1:0]   sys_addr_o;
  logic [DW-1:0]   sys_wdata_o;
  logic [DW/8-1:0] sys_sel_o;
  logic            sys_wen_o;
  logic            sys_ren_o;
  logic [DW-1:0]   sys_rdata_i;
  logic            sys_err_i;
  logic            sys_ack_i;

  modport slave (
    input  axi_awid_i, axi_awaddr_i, axi_awlen_i,
    input  axi_awsize_i, axi_awburst_i, axi_awvalid_i,
    output axi_awready_o,
    input  axi_wdata_i, axi_wstrb_i, axi_wlast_i,
    input  axi_wvalid_i,
    output axi_wready_o,
    output axi_bid_o, axi_bresp_o, axi_bvalid_o,
    input  axi_bready_i,
    input  axi_arid_i, axi_araddr_i, axi_arlen_i,
    input  axi_arsize_i, axi_arburst_i, axi_arvalid_i,
    output axi_arready_o,
    output axi_rid_o, axi_rdata_o, axi_rresp_o,
    output axi_rlast_o, axi_rvalid_o,
    input  axi_rready_i,
    output sys_addr_o, sys_wdata_o, sys_sel_o,
    output sys_wen_o, sys_ren_o,
    input  sys_rdata_i, sys_err_i, sys_ack_i
  );

  modport master (
    output axi_awid_i, axi_awaddr_i, axi_awlen_i,
    output axi_awsize_i, axi_awburst_i, axi_awvalid_i,
    input  axi_awready_o,
    output axi_wdata_i, axi_wstrb_i, axi_wlast_i,
    output axi_wvalid_i,
    input  axi_wready_o,
    input  axi_bid_o, axi_bresp_o, axi_bvalid_o,
    output axi_bready_i,
    output axi_arid_i, axi_araddr_i, axi_arlen_i,
    output axi_arsize_i, axi_arburst_i, axi_arvalid_i,
    input  axi_arready_o,
    input  axi_rid_o, axi_rdata_o, axi_rresp_o,
    input  axi_rlast_o, axi_rvalid_o,
    output axi_rready_i,
    input  sys_addr_o, sys_wdata_o, sys_sel_o,
    input  sys_wen_o, sys_ren_o,
    output sys_rdata_i, sys_err_i, sys_ack_i
  );
endinterface

// File: rtl/axi4_sys_bus_bridge.sv
// AXI4 burst slave that splits every burst into
// single-beat system bus accesses with timeout.
module axi4_sys_bus_bridge #(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int IW     = 12,
  parameter int TO_CYC = 255
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  axi4_sys_bus_bridge_if.slave bus
);
  localparam int SW = DW / 8;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [2:0] LSZ = 3'($clog2(SW));
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CYC);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_BUS, WR_RESP, RD_BUS, RD_DATA
  } state_t;

  state_t state, state_nx;

  logic          last_wr;
  logic [IW-1:0] id;
  logic [AW-1:0] addr, addr_nx, step, mask;
  logic [7:0]    len, cnt;
  logic [2:0]    size, sz;
  logic [1:0]    burst;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [TW-1:0] to_cnt;
  logic          err_acc, rlast;
  logic [1:0]    rresp, bresp;
  logic          grant_wr, grant_rd, in_bus, first;
  logic          rsv, skip, tout, done, berr, last;
  logic          unused_wlast;

  assign unused_wlast = bus.axi_wlast_i;

  // Arbitration, beat completion and next beat address.
  always_comb begin
    grant_wr = bus.axi_awvalid_i
             & (~bus.axi_arvalid_i | ~last_wr);
    grant_rd = bus.axi_arvalid_i & ~grant_wr;
    in_bus = (state == WR_BUS) | (state == RD_BUS);
    first = in_bus & (to_cnt == '0);
    rsv = burst == 2'b11;
    skip = rsv | ((state == WR_BUS) & (wstrb == '0));
    tout = to_cnt == TO_MAX;
    done = in_bus & (skip | bus.sys_ack_i | tout);
    berr = rsv | (~skip & (bus.sys_ack_i ?
                           bus.sys_err_i : tout));
    last = cnt == len;
    sz = (size > LSZ) ? LSZ : size;
    step = AW'(1) << sz;
    mask = ((AW'(len) + AW'(1)) << sz) - AW'(1);
    addr_nx = addr;
    unique case (burst)
      2'b01: addr_nx = addr + step;
      2'b10: addr_nx = (addr & ~mask)
                     | ((addr + step) & mask);
      default: addr_nx = addr;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state and handshake/strobe outputs.
  always_comb begin
    state_nx = state;
    bus.axi_awready_o = rstn_i & (state == IDLE) & grant_wr;
    bus.axi_arready_o = rstn_i & (state == IDLE) & grant_rd;
    bus.axi_wready_o = state == WR_DATA;
    bus.axi_bvalid_o = state == WR_RESP;
    bus.axi_rvalid_o = state == RD_DATA;
    bus.sys_wen_o = first & (state == WR_BUS) & ~skip;
    bus.sys_ren_o = first & (state == RD_BUS) & ~skip;
    bus.sys_sel_o = '0;
    unique case (state)
      IDLE: begin
        if (grant_wr)      state_nx = WR_DATA;
        else if (grant_rd) state_nx = RD_BUS;
      end
      WR_DATA: if (bus.axi_wvalid_i) state_nx = WR_BUS;
      WR_BUS: begin
        bus.sys_sel_o = wstrb;
        if (done) state_nx = last ? WR_RESP : WR_DATA;
      end
      WR_RESP: if (bus.axi_bready_i) state_nx = IDLE;
      RD_BUS: begin
        bus.sys_sel_o = '1;
        if (done) state_nx = RD_DATA;
      end
      RD_DATA: begin
        if (bus.axi_rready_i)
          state_nx = rlast ? IDLE : RD_BUS;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, beat data, counters and responses.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      last_wr <= 1'b1;
      id      <= '0;
      addr    <= '0;
      len     <= '0;
      size    <= '0;
      burst   <= '0;
      cnt     <= '0;
      to_cnt  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      err_acc <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
      bresp   <= OKAY;
    end else begin
      to_cnt <= (in_bus & ~done) ? to_cnt + TW'(1) : '0;
      unique case (state)
        IDLE: begin
          if (grant_wr | grant_rd) begin
            id      <= grant_wr ? bus.axi_awid_i
                                : bus.axi_arid_i;
            addr    <= grant_wr ? bus.axi_awaddr_i
                                : bus.axi_araddr_i;
            len     <= grant_wr ? bus.axi_awlen_i
                                : bus.axi_arlen_i;
            size    <= grant_wr ? bus.axi_awsize_i
                                : bus.axi_arsize_i;
            burst   <= grant_wr ? bus.axi_awburst_i
                                : bus.axi_arburst_i;
            last_wr <= grant_wr;
            cnt     <= '0;
            err_acc <= 1'b0;
          end
        end
        WR_DATA: begin
          if (bus.axi_wvalid_i) begin
            wdata <= bus.axi_wdata_i;
            wstrb <= bus.axi_wstrb_i;
          end
        end
        WR_BUS: begin
          if (done) begin
            err_acc <= err_acc | berr;
            if (last) begin
              bresp <= (err_acc | berr) ? SLVERR : OKAY;
            end else begin
              cnt  <= cnt + 8'd1;
              addr <= addr_nx;
            end
          end
        end
        RD_BUS: begin
          if (done) begin
            rdata <= (rsv | ~bus.sys_ack_i) ? '0
                                            : bus.sys_rdata_i;
            rresp <= berr ? SLVERR : OKAY;
            rlast <= last;
          end
        end
        RD_DATA: begin
          if (bus.axi_rready_i & ~rlast) begin
            cnt  <= cnt + 8'd1;
            addr <= addr_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.axi_bid_o   = id;
  assign bus.axi_bresp_o = bresp;
  assign bus.axi_rid_o   = id;
  assign bus.axi_rdata_o = rdata;
  assign bus.axi_rresp_o = rresp;
  assign bus.axi_rlast_o = rlast;
  assign bus.sys_addr_o  = addr;
  assign bus.sys_wdata_o = wdata;
endmodule

// File: tb/tb_axi4_sys_bus_bridge.sv
// Directed bench for the AXI4 burst bridge with a
// scripted single-beat bus responder.
module tb_axi4_sys_bus_bridge;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 12;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  axi4_sys_bus_bridge_if #(.DW(DW), .AW(AW), .IW(IW)) b ();

  axi4_sys_bus_bridge #(
    .DW(DW), .AW(AW), .IW(IW), .TO_CYC(8)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (b)
  );

  always #5 clk = ~clk;

  logic [31:0] lg_addr[$];
  logic [31:0] lg_wdata[$];
  logic [3:0]  lg_sel[$];
  logic        lg_wr[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic        rq_last[$];
  logic [11:0] rq_id[$];

  int ack_dly = 0;
  int drop_beat = 0;
  int nbeat = 0;
  int wcnt = 0;
  bit pend = 0;
  bit err_en = 0;
  bit dead_en = 0;

  // Bus responder: logs strobes, acks after ack_dly cycles.
  always @(negedge clk) begin
    b.sys_ack_i = 1'b0;
    b.sys_err_i = 1'b0;
    if (!rstn) begin
      pend = 0;
    end else begin
      if (b.sys_wen_o || b.sys_ren_o) begin
        lg_addr.push_back(b.sys_addr_o);
        lg_wdata.push_back(b.sys_wdata_o);
        lg_sel.push_back(b.sys_sel_o);
        lg_wr.push_back(b.sys_wen_o);
        nbeat++;
        if (nbeat != drop_beat) begin
          pend = 1;
          wcnt = ack_dly;
        end
      end
      if (pend) begin
        if (wcnt == 0) begin
          b.sys_ack_i = 1'b1;
          b.sys_err_i = err_en;
          b.sys_rdata_i = dead_en ? 32'hDEADBEEF
                                  : (32'hA500_0000 ^ b.sys_addr_o);
          pend = 0;
        end else begin
          wcnt--;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    lg_addr.delete();
    lg_wdata.delete();
    lg_sel.delete();
    lg_wr.delete();
    rq_data.delete();
    rq_resp.delete();
    rq_last.delete();
    rq_id.delete();
  endtask

  task automatic aw_send(input logic [11:0] id,
                         input logic [31:0] a,
                         input logic [7:0] len,
                         input logic [1:0] bt);
    int n = 0;
    b.axi_awid_i = id;
    b.axi_awaddr_i = a;
    b.axi_awlen_i = len;
    b.axi_awsize_i = 3'd2;
    b.axi_awburst_i = bt;
    b.axi_awvalid_i = 1'b1;
    #1;
    while (!b.axi_awready_o && n < 20) begin
      tick();
      n++;
    end
    chk("aw_accept", n < 20, 1);
    tick();
    b.axi_awvalid_i = 1'b0;
  endtask

  task automatic ar_send(input logic [11:0] id,
                         input logic [31:0] a,
                         input logic [7:0] len,
                         input logic [1:0] bt);
    int n = 0;
    b.axi_arid_i = id;
    b.axi_araddr_i = a;
    b.axi_arlen_i = len;
    b.axi_arsize_i = 3'd2;
    b.axi_arburst_i = bt;
    b.axi_arvalid_i = 1'b1;
    #1;
    while (!b.axi_arready_o && n < 20) begin
      tick();
      n++;
    end
    chk("ar_accept", n < 20, 1);
    tick();
    b.axi_arvalid_i = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d,
                        input logic [3:0] s);
    int n = 0;
    b.axi_wdata_i = d;
    b.axi_wstrb_i = s;
    b.axi_wvalid_i = 1'b1;
    #1;
    while (!b.axi_wready_o && n < 50) begin
      tick();
      n++;
    end
    chk("w_accept", n < 50, 1);
    tick();
    b.axi_wvalid_i = 1'b0;
  endtask

  task automatic b_wait(input logic [11:0] id,
                        input logic [1:0] resp);
    int n = 0;
    b.axi_bready_i = 1'b1;
    #1;
    while (!b.axi_bvalid_o && n < 100) begin
      tick();
      n++;
    end
    chk("b_seen", n < 100, 1);
    chk("bid", b.axi_bid_o, id);
    chk("bresp", b.axi_bresp_o, resp);
    tick();
    b.axi_bready_i = 1'b0;
  endtask

  task automatic r_collect(input int nb, input bit tog);
    int got = 0;
    int cyc = 0;
    logic [63:0] hold = '0;
    bit held = 0;
    while (got < nb && cyc < 300) begin
      b.axi_rready_i = tog ? ~b.axi_rready_i : 1'b1;
      #1;
      if (b.axi_rvalid_o) begin
        if (held)
          chk("r_hold", {b.axi_rresp_o, b.axi_rlast_o,
                         b.axi_rdata_o}, hold);
        held = !b.axi_rready_i;
        hold = {29'd0, b.axi_rresp_o, b.axi_rlast_o,
                b.axi_rdata_o};
        if (b.axi_rready_i) begin
          rq_data.push_back(b.axi_rdata_o);
          rq_resp.push_back(b.axi_rresp_o);
          rq_last.push_back(b.axi_rlast_o);
          rq_id.push_back(b.axi_rid_o);
          got++;
        end
      end
      tick();
      cyc++;
    end
    b.axi_rready_i = 1'b0;
    chk("r_beats", got, nb);
  endtask

  initial begin
    int n;
    int g;
    logic [3:0] gseq;
    b.axi_awid_i = '0;
    b.axi_awaddr_i = '0;
    b.axi_awlen_i = '0;
    b.axi_awsize_i = '0;
    b.axi_awburst_i = '0;
    b.axi_awvalid_i = 1'b0;
    b.axi_wdata_i = '0;
    b.axi_wstrb_i = '0;
    b.axi_wlast_i = 1'b0;
    b.axi_wvalid_i = 1'b0;
    b.axi_bready_i = 1'b0;
    b.axi_arid_i = '0;
    b.axi_araddr_i = '0;
    b.axi_arlen_i = '0;
    b.axi_arsize_i = '0;
    b.axi_arburst_i = '0;
    b.axi_arvalid_i = 1'b0;
    b.axi_rready_i = 1'b0;
    b.sys_rdata_i = '0;
    b.sys_err_i = 1'b0;
    b.sys_ack_i = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_ready", {b.axi_awready_o, b.axi_arready_o,
                      b.axi_wready_o}, 0);
    chk("rst_valid", {b.axi_bvalid_o, b.axi_rvalid_o}, 0);
    chk("rst_strobe", {b.sys_wen_o, b.sys_ren_o,
                       b.sys_sel_o}, 0);
    chk("rst_addr", b.sys_addr_o, 0);
    chk("rst_rdata", {b.axi_rdata_o, b.axi_rresp_o,
                      b.axi_rlast_o}, 0);
    chk("rst_bresp", {b.axi_bresp_o, b.axi_bid_o}, 0);
    rstn = 1'b1;
    tick();

    // Single write, ack two cycles after the strobe.
    clr_logs();
    ack_dly = 2;
    aw_send(12'h03A, 32'h4000_0010, 8'd0, 2'b01);
    w_send(32'hDEADBEEF, 4'hF);
    chk("wen_latency", b.sys_wen_o, 1);
    tick();
    chk("wen_pulse", b.sys_wen_o, 0);
    b_wait(12'h03A, 2'b00);
    chk("w1_count", lg_addr.size(), 1);
    chk("w1_addr", lg_addr[0], 32'h4000_0010);
    chk("w1_sel", lg_sel[0], 4'hF);
    chk("w1_data", lg_wdata[0], 32'hDEADBEEF);
    chk("w1_wr", lg_wr[0], 1);

    // INCR read under rready backpressure.
    clr_logs();
    ack_dly = 1;
    ar_send(12'h005, 32'h100, 8'd3, 2'b01);
    chk("ren_latency", b.sys_ren_o, 1);
    chk("rd_sel", b.sys_sel_o, 4'hF);
    r_collect(4, 1);
    chk("incr_count", lg_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("incr_addr", lg_addr[i], 32'h100 + 4 * i);
      chk("incr_rd", lg_wr[i], 0);
      chk("incr_data", rq_data[i],
          32'hA500_0000 ^ (32'h100 + 4 * i));
      chk("incr_last", rq_last[i], i == 3);
      chk("incr_resp", rq_resp[i], 0);
    end
    chk("incr_rid", rq_id[0], 12'h005);

    // WRAP read.
    clr_logs();
    ar_send(12'h006, 32'h118, 8'd3, 2'b10);
    r_collect(4, 0);
    chk("wrap_a0", lg_addr[0], 32'h118);
    chk("wrap_a1", lg_addr[1], 32'h11C);
    chk("wrap_a2", lg_addr[2], 32'h110);
    chk("wrap_a3", lg_addr[3], 32'h114);

    // Timeout on beat 2 of a 3-beat write.
    clr_logs();
    nbeat = 0;
    drop_beat = 2;
    aw_send(12'h007, 32'h200, 8'd2, 2'b01);
    w_send(32'h1111_1111, 4'hF);
    w_send(32'h2222_2222, 4'hF);
    n = 0;
    while (!b.axi_wready_o && n < 50) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 9);
    w_send(32'h3333_3333, 4'hF);
    b_wait(12'h007, 2'b10);
    drop_beat = 0;
    chk("to_count", lg_addr.size(), 3);
    chk("to_a2", lg_addr[2], 32'h208);
    chk("to_d2", lg_wdata[2], 32'h3333_3333);

    // Write with zero strobes: no bus access, OKAY.
    clr_logs();
    aw_send(12'h002, 32'h240, 8'd0, 2'b01);
    w_send(32'h5555_5555, 4'h0);
    b_wait(12'h002, 2'b00);
    chk("nostrb_count", lg_addr.size(), 0);

    // Read with bus error, same-cycle ack.
    clr_logs();
    ack_dly = 0;
    err_en = 1;
    dead_en = 1;
    ar_send(12'h004, 32'h300, 8'd0, 2'b01);
    r_collect(1, 0);
    err_en = 0;
    dead_en = 0;
    chk("err_resp", rq_resp[0], 2'b10);
    chk("err_data", rq_data[0], 32'hDEADBEEF);
    chk("err_last", rq_last[0], 1);
    chk("err_rid", rq_id[0], 12'h004);

    // Reserved burst type: SLVERR, no bus access.
    clr_logs();
    ar_send(12'h008, 32'h380, 8'd1, 2'b11);
    r_collect(2, 0);
    chk("rsv_count", lg_addr.size(), 0);
    chk("rsv_resp0", rq_resp[0], 2'b10);
    chk("rsv_resp1", rq_resp[1], 2'b10);
    chk("rsv_data", rq_data[1], 0);
    chk("rsv_last", {rq_last[0], rq_last[1]}, 2'b01);

    // Contended grants after a fresh reset.
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    b.axi_awid_i = 12'h001;
    b.axi_awaddr_i = 32'h500;
    b.axi_awlen_i = 8'd0;
    b.axi_awburst_i = 2'b01;
    b.axi_arid_i = 12'h002;
    b.axi_araddr_i = 32'h600;
    b.axi_arlen_i = 8'd0;
    b.axi_arburst_i = 2'b01;
    b.axi_wdata_i = 32'h0BAD_F00D;
    b.axi_wstrb_i = 4'hF;
    b.axi_wvalid_i = 1'b1;
    b.axi_bready_i = 1'b1;
    b.axi_rready_i = 1'b1;
    b.axi_awvalid_i = 1'b1;
    b.axi_arvalid_i = 1'b1;
    g = 0;
    n = 0;
    gseq = '0;
    while (g < 4 && n < 200) begin
      #1;
      chk("rdy_idle", (b.axi_awready_o | b.axi_arready_o) &
          (b.axi_wready_o | b.axi_rvalid_o | b.axi_bvalid_o |
           b.sys_wen_o | b.sys_ren_o), 0);
      if (b.axi_awready_o || b.axi_arready_o) begin
        chk("rdy_both", b.axi_awready_o & b.axi_arready_o, 0);
        gseq[g] = b.axi_awready_o;
        g++;
      end
      tick();
      n++;
      if (g == 4) begin
        b.axi_awvalid_i = 1'b0;
        b.axi_arvalid_i = 1'b0;
      end
    end
    chk("grant_seq", gseq, 4'b1010);
    repeat (10) tick();
    b.axi_wvalid_i = 1'b0;
    b.axi_bready_i = 1'b0;
    b.axi_rready_i = 1'b0;
    chk("arb_settled", {b.axi_bvalid_o, b.axi_rvalid_o,
                        b.axi_wready_o}, 0);

    // Reset during beat 2 of an 8-beat read.
    clr_logs();
    ack_dly = 2;
    nbeat = 0;
    b.axi_rready_i = 1'b1;
    ar_send(12'h006, 32'h700, 8'd7, 2'b01);
    n = 0;
    while (nbeat < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_beat2", nbeat, 2);
    rstn = 1'b0;
    b.axi_rready_i = 1'b0;
    tick();
    chk("mid_valid", {b.axi_rvalid_o, b.axi_bvalid_o,
                      b.axi_wready_o, b.axi_arready_o,
                      b.axi_awready_o}, 0);
    chk("mid_bus", {b.sys_ren_o, b.sys_wen_o,
                    b.sys_sel_o}, 0);
    chk("mid_addr", b.sys_addr_o, 0);
    chk("mid_rdata", {b.axi_rdata_o, b.axi_rlast_o,
                      b.axi_rid_o}, 0);
    rstn = 1'b1;
    tick();
    clr_logs();
    ack_dly = 1;
    ar_send(12'h009, 32'h800, 8'd0, 2'b01);
    r_collect(1, 0);
    chk("post_addr", lg_addr[0], 32'h800);
    chk("post_data", rq_data[0], 32'hA500_0800);
    chk("post_resp", rq_resp[0], 0);
    chk("post_last", rq_last[0], 1);
    chk("post_rid", rq_id[0], 12'h009);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
